// File: rtl/jt10_adpcm_chatt_pkg.sv
// Shared constants for the jt10 ADPCM-A channel attenuation path.
package jt10_adpcm_chatt_pkg;

  localparam logic [2:0] CH0   = 3'd0;
  localparam logic [2:0] CH1   = 3'd1;
  localparam logic [2:0] CH2   = 3'd2;
  localparam logic [2:0] CH3   = 3'd3;
  localparam logic [2:0] CH4   = 3'd4;
  localparam logic [2:0] CH5   = 3'd5;
  localparam logic [2:0] TOTAL = 3'd6;

  localparam int         NUM_CH   = 6;
  localparam logic [5:0] MUTE_ATT = 6'd63;

  // 0.75 dB mantissa steps; the coarse 6 dB part is a right shift
  function automatic logic [8:0] att_mant(input logic [2:0] idx);
    logic [8:0] m;
    case (idx)
      3'd0:    m = 9'd256;
      3'd1:    m = 9'd235;
      3'd2:    m = 9'd215;
      3'd3:    m = 9'd197;
      3'd4:    m = 9'd181;
      3'd5:    m = 9'd166;
      3'd6:    m = 9'd152;
      default: m = 9'd140;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/jt10_adpcm_chatt_mul.sv
// Stage-2 gain: signed sample times mantissa, then floor shifts by 8 and sh.
module jt10_adpcm_chatt_mul
  import jt10_adpcm_chatt_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic [15:0] pcm,
  input  logic [8:0]  mant,
  input  logic [2:0]  sh,
  output logic [15:0] pcm_att
);

  logic signed [24:0] pcm_x, mant_x, prod, scaled;

  always_comb begin
    pcm_x  = {{9{pcm[15]}}, pcm};
    mant_x = {16'd0, mant};
    prod   = pcm_x * mant_x;
    scaled = (prod >>> 8) >>> sh;
  end

  // gain never exceeds 1, so the low 16 bits carry the whole result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   pcm_att <= 16'd0;
    else if (cen) pcm_att <= 16'(scaled);
  end

endmodule

// File: rtl/jt10_adpcm_chatt.sv
// ADPCM-A per-channel level/total attenuation and pan gating, two cen stages.
module jt10_adpcm_chatt
  import jt10_adpcm_chatt_pkg::*;
#(
  parameter int LR = 0
) (
  input  logic        rst_n,
  input  logic        clk,
  input  logic        cen,
  input  logic [5:0]  cur_ch,
  input  logic [5:0]  en_ch,
  input  logic        match,
  input  logic [15:0] pcm_dec,
  input  logic        wr,
  input  logic [2:0]  addr,
  input  logic [7:0]  din,
  output logic [5:0]  cur_ch_o,
  output logic [5:0]  en_ch_o,
  output logic        match_o,
  output logic        en_sum,
  output logic [15:0] pcm_att
);

  logic [7:0] ch_regs [NUM_CH];
  logic [5:0] total;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) ch_regs[i] <= 8'd0;
      total <= 6'd0;
    end else if (wr) begin
      if (addr == TOTAL) total <= din[5:0];
      for (int i = 0; i < NUM_CH; i++)
        if (addr == 3'(i)) ch_regs[i] <= din;
    end
  end

  // one-hot mux; anything else reads as level 0 / pan 00, i.e. muted
  logic       onehot;
  logic [7:0] sel;
  logic [6:0] att_sum;
  logic [5:0] att;
  logic       pan;

  always_comb begin
    onehot = (en_ch != 6'd0) && ((en_ch & (en_ch - 6'd1)) == 6'd0);
    sel    = 8'd0;
    if (onehot)
      for (int i = 0; i < NUM_CH; i++)
        if (en_ch[i]) sel = sel | ch_regs[i];
    att_sum = {1'b0, ~sel[5:0]} + {1'b0, ~total};
    att     = (att_sum > {1'b0, MUTE_ATT}) ? MUTE_ATT : 6'(att_sum);
    pan     = (LR != 0) ? sel[6] : sel[7];
  end

  // stage 1
  logic [8:0]  mant1;
  logic [2:0]  sh1;
  logic [15:0] pcm1;
  logic        pan1, mute1, match1;
  logic [5:0]  cur1, en1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mant1  <= 9'd0;
      sh1    <= 3'd0;
      pcm1   <= 16'd0;
      pan1   <= 1'b0;
      mute1  <= 1'b0;
      match1 <= 1'b0;
      cur1   <= 6'd0;
      en1    <= 6'd0;
    end else if (cen) begin
      mant1  <= att_mant(att[2:0]);
      sh1    <= att[5:3];
      pcm1   <= pcm_dec;
      pan1   <= pan;
      mute1  <= (att == MUTE_ATT);
      match1 <= match;
      cur1   <= cur_ch;
      en1    <= en_ch;
    end
  end

  // stage 2
  jt10_adpcm_chatt_mul u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .cen     (cen),
    .pcm     (mute1 ? 16'd0 : pcm1),
    .mant    (mant1),
    .sh      (sh1),
    .pcm_att (pcm_att)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_ch_o <= 6'd0;
      en_ch_o  <= 6'd0;
      match_o  <= 1'b0;
      en_sum   <= 1'b0;
    end else if (cen) begin
      cur_ch_o <= cur1;
      en_ch_o  <= en1;
      match_o  <= match1;
      en_sum   <= pan1 & ~mute1;
    end
  end

endmodule

// File: doc/jt10_adpcm_chatt.md
JT10_ADPCM_CHATT -- requirements
Module: jt10_adpcm_chatt

Interface
REQ-001 SHALL have parameter LR, default 0, selecting which pan bit gates en_sum: 0 selects left (bit 7), 1 selects right (bit 6).
REQ-002 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have port clk  input  1  CPU clock; the block uses this single clock.
REQ-004 SHALL have port cen  input  1  111 kHz pipeline enable.
REQ-005 SHALL have port cur_ch  input  6  one-hot slot of the ADPCM-A channel counter.
REQ-006 SHALL have port en_ch  input  6  one-hot channel whose decoded sample is on pcm_dec.
REQ-007 SHALL have port match  input  1  pcm_dec is valid for en_ch in this cen.
REQ-008 SHALL have port pcm_dec  input  16  signed decoded channel sample.
REQ-009 SHALL have port wr  input  1  register write strobe, sampled on clk and not gated by cen.
REQ-010 SHALL have port addr  input  3  write address: 0-5 select the channel, 6 selects total level, 7 is ignored.
REQ-011 SHALL have port din  input  8  write data: for channels, [7:6] is pan L/R and [5:0] is level; for total level, [5:0].
REQ-012 SHALL have port cur_ch_o  output  6  cur_ch delayed to align with pcm_att.
REQ-013 SHALL have port en_ch_o  output  6  en_ch delayed to align with pcm_att.
REQ-014 SHALL have port match_o  output  1  match delayed to align with pcm_att.
REQ-015 SHALL have port en_sum  output  1  aligned channel enable, equal to the selected pan bit.
REQ-016 SHALL have port pcm_att  output  16  signed attenuated sample, feeding the accumulator stage as pcm_in.

Function
REQ-017 SHALL hold a register file of six 8-bit channel registers plus one 6-bit total-level register, written when wr=1 at a clk edge.
REQ-018 SHALL treat an address 7 write as a no-op.
REQ-019 SHALL use the pre-write register value in stage 1 when wr and cen coincide on the same clk edge; the new value applies from the next cen.
REQ-020 SHALL select a channel's register with en_ch as a one-hot mux; a non-one-hot en_ch SHALL select nothing, giving level 0 and pan 00.
REQ-021 SHALL compute, in stage 1 on cen, att = (63-level) + (63-total), 7 bits unsigned, clipped to 63.
REQ-022 SHALL register in stage 1, on cen: mant = LUT[att[2:0]], sh = att[5:3], pcm_dec, the pan bit, cur_ch, en_ch and match.
REQ-023 SHALL use the LUT values 256, 235, 215, 197, 181, 166, 152, 140 (0.75 dB steps, 9-bit unsigned).
REQ-024 SHALL compute, in stage 2 on cen: product = pcm * mant (signed 25-bit), then (product >>> 8) >>> sh, using arithmetic shifts that floor toward minus infinity.
REQ-025 SHALL register in stage 2 the result truncated to 16 bits (no overflow is possible, since the gain is ≤ 1), together with the aligned controls.
REQ-026 SHALL force pcm_att to 0 and en_sum to 0 in stage 2 when att=63 (mute).
REQ-027 SHALL have a latency of exactly 2 cen pulses from any input to the corresponding output.
REQ-028 SHALL hold all outputs stable between cen pulses.
REQ-029 SHALL make att=0 an exact passthrough: pcm_att = pcm_dec, including -32768.
REQ-030 SHALL propagate match=0 slots through the pipeline with their data unchanged; the consumer ignores them.

Reset
REQ-031 SHALL, on rst_n low, asynchronously clear the register file, both pipeline stages and all outputs to 0.
REQ-032 SHALL start from all-muted state after reset: att=126 clipped to 63 and pan 00.
REQ-033 SHALL discard in-flight pipeline data when reset is asserted mid-operation; the first valid output is the second cen after rst_n rises.

Structure
REQ-034 SHALL place the LUT constants, the address codes (CH0-CH5, TOTAL=6) and the mute threshold (63) in a shared package for the jt10 ADPCM blocks.
REQ-035 SHALL implement the stage-2 multiply/shift as one natural sub-module, jt10_adpcm_chatt_mul: inputs pcm, mant and sh; one registered output.

Verification
REQ-036 SHALL cover: ch0 din=0xFF, total=63, pcm_dec=0x4000 with en_ch=000001, match=1 -> pcm_att=0x4000, en_sum=1, match_o=1 after 2 cen.
REQ-037 SHALL cover: ch2 level=55, total=63 (att=8, mant 256, sh 1), pcm_dec=-1000 -> pcm_att=-500.
REQ-038 SHALL cover: ch1 level=62, total=63 (att=1), pcm_dec=1000 -> pcm_att=917 (1000*235>>8).
REQ-039 SHALL cover: level=0 or total=0 -> pcm_att=0 and en_sum=0, regardless of pcm_dec=0x7FFF.
REQ-040 SHALL cover: with LR=1 and din=0xBF (pan L only) -> en_sum=0 and pcm_att still attenuated; with LR=0 -> en_sum=1.
REQ-041 SHALL cover: wr to ch0 on the same edge as cen -> that sample uses the old level and the next sample uses the new one; rst_n pulsed mid-stream -> outputs 0 immediately.
